mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
Parametrised MIPS-32 memory-access pipeline stage. It sits between EX and WB and drives a data memory through a req/gnt/rvalid handshake with variable latency. Beyond word accesses it adds byte and halfword loads and stores, sign and zero extension, byte enables, and ALU-result pass-through. It stalls upstream through in_ready while a memory transaction is outstanding.

Parameters:
ADDR_W, 32, width of effective address and mem_addr
DATA_W, 32, data width; only 32 is legal, elaborated check
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX result valid
in_ready  out  1  stage can accept
in_opcode  in  6  MIPS primary opcode
in_rt  in  REG_AW  destination/source register address
in_rt_value  in  DATA_W  store data
in_eff_addr  in  ADDR_W  effective address, or ALU result for non-memory ops
in_wr_en  in  1  non-memory op writes the register file
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0
mem_be  out  4  byte enables
mem_wdata  out  DATA_W  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
wb_valid  out  1  one-cycle WB pulse
wb_we  out  1  write register file
wb_addr  out  REG_AW  destination register
wb_data  out  DATA_W  write data
exc_misalign  out  1  one-cycle misaligned-access pulse (feature only)

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready, which is 1. Reset mid-transaction drops mem_req immediately and discards the pending access.
- Opcodes:
  - Loads: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
  - Stores: SB 101000, SH 101001, SW 101011.
  - Any other opcode is a non-memory op.
- FSM states: IDLE, REQ, WAIT_RD. in_ready = 1 only in IDLE. Accept = in_valid & in_ready. Opcode, rt, address and data are captured at accept.
- IDLE, non-memory op: at the next edge wb_valid=1, wb_data=in_eff_addr, wb_addr=in_rt, wb_we=in_wr_en. State stays IDLE, so throughput is 1 per cycle.
- IDLE, memory op: go to REQ. mem_req, mem_we, mem_addr, mem_be and mem_wdata are driven from registers and held stable until gnt.
- REQ: if mem_gnt, stores return to IDLE with wb_valid=1 and wb_we=0; loads go to WAIT_RD. Without gnt, stay in REQ indefinitely.
- WAIT_RD: on mem_rvalid, select the lane by addr[1:0] (little-endian), then extend:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - At that edge wb_valid=1, wb_we=1, wb_data=extended value. Return to IDLE.
- Minimum load latency is accept + 3 edges (gnt in the first REQ cycle, rvalid in the next cycle).
- mem_rvalid outside WAIT_RD is ignored. A WAIT_RD cycle with rvalid=0 holds state.
- Byte enables:
  - SB: 0001 shifted by addr[1:0], data byte replicated in all 4 lanes.
  - SH: 0011 or 1100 by addr[1], halfword replicated.
  - SW and all loads: 1111.
- wb_we is forced to 0 whenever wb_addr==0, for both loads and pass-through ops.
- wb_valid is registered and lasts exactly one cycle; wb_data and wb_addr hold their last values otherwise.

Optional Feature:
MEM_STAGE_MISALIGN_TRAP_EN
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no mem_req. At the next edge exc_misalign=1 and wb_valid=1 with wb_we=0; state stays IDLE.
- Undefined: the offending low address bits are ignored (halfword uses addr[1], word uses lane 0), and exc_misalign is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - opcode localparams;
  - state enum {IDLE, REQ, WAIT_RD};
  - access-size typedef {SZ_B, SZ_H, SZ_W}.
- Sub-module mem_lane_align: combinational byte-enable/wdata replication for stores plus load lane-select and extension, shared by both paths.

Test Plan:
- Back-to-back: ADDIU-type op, in_wr_en=1, rt=5, eff=0x1234, then rt=6, eff=0x5678 on consecutive cycles -> wb_valid on consecutive cycles with 0x1234 then 0x5678; in_ready stays 1.
- LW, addr 0x100, gnt delayed 3 cycles, rdata 0xDEADBEEF -> mem_req held 4 cycles, in_ready=0 throughout, wb_data=0xDEADBEEF, wb_we=1.
- LB at 0x103 with rdata 0x80FF0102 -> wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- SB at 0x101, rt_value 0x000000AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1; SH at 0x102 -> mem_be=1100.
- LW with rt=0 -> wb_valid=1, wb_we=0. rst_n low while in WAIT_RD -> mem_req=0 and state IDLE; a later rvalid produces no wb_valid.
- With the feature defined, LW at 0x102 -> no mem_req, exc_misalign pulse. Without it -> mem_addr=0x100, mem_be=1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS-32 memory stage: opcodes, FSM states, access sizes
// and small opcode-decode helpers.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_t op_size(input logic [5:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB})
            return SZ_B;
        else if (op inside {OP_LH, OP_LHU, OP_SH})
            return SZ_H;
        else
            return SZ_W;
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return op inside {OP_LB, OP_LH};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables / data replication and load
// lane selection with sign or zero extension (little-endian).
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  size_t       st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  size_t       ld_size,
    input  logic        ld_signed,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be = 4'b1111;
        case (st_size)
            SZ_B:    st_be = 4'b0001 << st_addr_lo;
            SZ_H:    st_be = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            default: st_be = 4'b1111;
        endcase
    end

    // Each lane takes the byte it would hold if the access were naturally placed there.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_wdata[8*gi +: 8] = (st_size == SZ_B) ? st_data[7:0] :
                                         (st_size == SZ_H) ? st_data[8*(gi%2) +: 8] :
                                                             st_data[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = ld_rdata[8*ld_addr_lo +: 8];
    assign ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            SZ_B:    ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MIPS-32 memory-access stage with req/gnt/rvalid data-memory handshake.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [DATA_W-1:0] in_rt_value,
    input  logic [ADDR_W-1:0] in_eff_addr,
    input  logic              in_wr_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_misalign
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("mem_stage_hs: DATA_W must be 32");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [5:0]        op_reg;
    logic [REG_AW-1:0] rt_reg;
    logic [1:0]        addr_lo_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_be_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              wb_valid_reg, wb_we_reg;
    logic [REG_AW-1:0] wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg;

    logic        accept, in_is_mem, in_is_store, trap;
    size_t       in_size;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign in_ready    = (state_reg == IDLE);
    assign accept      = in_valid & in_ready;
    assign in_is_store = is_store(in_opcode);
    assign in_is_mem   = is_load(in_opcode) | in_is_store;
    assign in_size     = op_size(in_opcode);

    mem_lane_align u_align (
        .st_size    (in_size),
        .st_addr_lo (in_eff_addr[1:0]),
        .st_data    (in_rt_value),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_size    (op_size(op_reg)),
        .ld_signed  (op_signed(op_reg)),
        .ld_addr_lo (addr_lo_reg),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic exc_reg;

    assign trap = in_is_mem &&
                  ((in_size == SZ_H && in_eff_addr[0]) ||
                   (in_size == SZ_W && in_eff_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exc_reg <= 1'b0;
        else
            exc_reg <= accept & trap;
    end

    assign exc_misalign = exc_reg;
`else
    assign trap         = 1'b0;
    assign exc_misalign = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && in_is_mem && !trap) state_next = REQ;
            REQ:     if (mem_gnt) state_next = is_store(op_reg) ? IDLE : WAIT_RD;
            WAIT_RD: if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= '0;
            rt_reg        <= '0;
            addr_lo_reg   <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
            wb_valid_reg  <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_addr_reg   <= '0;
            wb_data_reg   <= '0;
        end else begin
            wb_valid_reg <= 1'b0;
            if (accept) begin
                if (!in_is_mem) begin
                    wb_valid_reg <= 1'b1;
                    wb_we_reg    <= in_wr_en && (in_rt != '0);
                    wb_addr_reg  <= in_rt;
                    wb_data_reg  <= DATA_W'(in_eff_addr);
                end else if (trap) begin
                    wb_valid_reg <= 1'b1;
                    wb_we_reg    <= 1'b0;
                    wb_addr_reg  <= in_rt;
                end else begin
                    op_reg        <= in_opcode;
                    rt_reg        <= in_rt;
                    addr_lo_reg   <= in_eff_addr[1:0];
                    mem_we_reg    <= in_is_store;
                    mem_addr_reg  <= {in_eff_addr[ADDR_W-1:2], 2'b00};
                    mem_be_reg    <= in_is_store ? st_be : 4'b1111;
                    mem_wdata_reg <= st_wdata;
                end
            end
            if (state_reg == REQ && mem_gnt) begin
                mem_we_reg <= 1'b0;
                if (is_store(op_reg)) begin
                    wb_valid_reg <= 1'b1;
                    wb_we_reg    <= 1'b0;
                    wb_addr_reg  <= rt_reg;
                end
            end
            if (state_reg == WAIT_RD && mem_rvalid) begin
                wb_valid_reg <= 1'b1;
                wb_we_reg    <= (rt_reg != '0);
                wb_addr_reg  <= rt_reg;
                wb_data_reg  <= ld_data;
            end
        end
    end

    assign mem_req   = (state_reg == REQ);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_we     = wb_we_reg;
    assign wb_addr   = wb_addr_reg;
    assign wb_data   = wb_data_reg;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed cases plus randomized transactions
// against a byte-arithmetic reference model; honours MEM_STAGE_MISALIGN_TRAP_EN.
module tb_mem_stage_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_opcode = '0;
    logic [4:0]  in_rt = '0;
    logic [31:0] in_rt_value = '0;
    logic [31:0] in_eff_addr = '0;
    logic        in_wr_en = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exc_misalign;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.ADDR_W(32), .DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rt(in_rt), .in_rt_value(in_rt_value), .in_eff_addr(in_eff_addr),
        .in_wr_en(in_wr_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exc_misalign(exc_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 0 = non-memory, 1 = load, 2 = store
    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: return 1;
            6'b101000, 6'b101001, 6'b101011: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int bytes_of(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100100, 6'b101000: return 1;
            6'b100001, 6'b100101, 6'b101001: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [31:0] addr);
        int n = bytes_of(op);
        if (kind_of(op) == 0) return 1'b0;
        return (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] exp_be(input logic [5:0] op, input logic [31:0] addr);
        longint v;
        int n = bytes_of(op);
        if (kind_of(op) == 1 || n == 4) v = 15;
        else if (n == 1) v = longint'(1) << (addr % 4);
        else v = longint'(3) << (2 * ((addr / 2) % 2));
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] val);
        longint v;
        int n = bytes_of(op);
        if (n == 1) v = longint'(val % 256) * 64'h01010101;
        else if (n == 2) v = longint'(val % 65536) * 64'h00010001;
        else v = longint'(val);
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint v;
        longint r = longint'(rdata);
        int n = bytes_of(op);
        if (n == 1) begin
            v = (r >> (8 * (addr % 4))) % 256;
            if (op == 6'b100000 && v >= 128) v = v - 256;
        end else if (n == 2) begin
            v = (r >> (16 * ((addr / 2) % 2))) % 65536;
            if (op == 6'b100001 && v >= 32768) v = v - 65536;
        end else begin
            v = r;
        end
        return v[31:0];
    endfunction

    task automatic do_txn(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] val,
                          input logic [31:0] addr, input logic wr_en, input int gdly,
                          input int rdly, input logic [31:0] rdata);
        int  kind = kind_of(op);
        logic trap_on;
        logic [31:0] exp;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        trap_on = 1'b1;
`else
        trap_on = 1'b0;
`endif
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_opcode = op; in_rt = rt; in_rt_value = val;
        in_eff_addr = addr; in_wr_en = wr_en;
        step();
        in_valid = 1'b0;
        if (kind == 0) begin
            chk("pass_valid", 32'(wb_valid), 32'd1);
            chk("pass_data", wb_data, addr);
            chk("pass_addr", 32'(wb_addr), 32'(rt));
            chk("pass_we", 32'(wb_we), 32'(wr_en && rt != 0));
            chk("pass_ready", 32'(in_ready), 32'd1);
            $display("txn alu op=%b rt=%0d data=%08h we=%0d", op, rt, wb_data, wb_we);
            return;
        end
        if (trap_on && is_misaligned(op, addr)) begin
            chk("trap_exc", 32'(exc_misalign), 32'd1);
            chk("trap_wbv", 32'(wb_valid), 32'd1);
            chk("trap_wbwe", 32'(wb_we), 32'd0);
            chk("trap_noreq", 32'(mem_req), 32'd0);
            chk("trap_ready", 32'(in_ready), 32'd1);
            step();
            chk("trap_exc_pulse", 32'(exc_misalign), 32'd0);
            $display("txn trap op=%b addr=%08h", op, addr);
            return;
        end
        chk("req_first", 32'(mem_req), 32'd1);
        chk("req_we", 32'(mem_we), 32'(kind == 2));
        chk("req_addr", mem_addr, (addr / 4) * 4);
        chk("req_be", 32'(mem_be), exp_be(op, addr));
        if (kind == 2) chk("req_wdata", mem_wdata, exp_wdata(op, val));
        chk("req_exc", 32'(exc_misalign), 32'd0);
        for (int i = 0; i < gdly; i++) begin
            mem_rvalid = 1'($urandom % 2);
            mem_rdata  = $urandom;
            step();
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("req_busy", 32'(in_ready), 32'd0);
            chk("req_nowb", 32'(wb_valid), 32'd0);
        end
        mem_gnt = 1'b1;
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk("gnt_req_drop", 32'(mem_req), 32'd0);
        if (kind == 2) begin
            chk("st_wbv", 32'(wb_valid), 32'd1);
            chk("st_wbwe", 32'(wb_we), 32'd0);
            chk("st_ready", 32'(in_ready), 32'd1);
            $display("txn store op=%b addr=%08h be=%04b gdly=%0d", op, addr, exp_be(op, addr), gdly);
            return;
        end
        for (int i = 0; i < rdly; i++) begin
            chk("rd_wait_nowb", 32'(wb_valid), 32'd0);
            chk("rd_wait_busy", 32'(in_ready), 32'd0);
            step();
        end
        chk("rd_wait_nowb", 32'(wb_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        exp = exp_load(op, addr, rdata);
        chk("ld_wbv", 32'(wb_valid), 32'd1);
        chk("ld_wbwe", 32'(wb_we), 32'(rt != 0));
        chk("ld_data", wb_data, exp);
        chk("ld_addr", 32'(wb_addr), 32'(rt));
        chk("ld_ready", 32'(in_ready), 32'd1);
        $display("txn load op=%b addr=%08h rdata=%08h data=%08h rt=%0d", op, addr, rdata, wb_data, rt);
    endtask

    logic [5:0] op_pool [11] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                 6'b101000, 6'b101001, 6'b101011,
                                 6'b001001, 6'b000000, 6'b001111};

    initial begin
        #1;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbwe", 32'(wb_we), 32'd0);
        chk("rst_wbaddr", 32'(wb_addr), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_exc", 32'(exc_misalign), 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back pass-through ops
        in_valid = 1'b1; in_opcode = 6'b001001; in_wr_en = 1'b1; in_rt = 5'd5; in_eff_addr = 32'h1234;
        step();
        chk("b2b_v0", 32'(wb_valid), 32'd1);
        chk("b2b_d0", wb_data, 32'h1234);
        chk("b2b_a0", 32'(wb_addr), 32'd5);
        chk("b2b_rdy", 32'(in_ready), 32'd1);
        in_rt = 5'd6; in_eff_addr = 32'h5678;
        step();
        in_valid = 1'b0;
        chk("b2b_v1", 32'(wb_valid), 32'd1);
        chk("b2b_d1", wb_data, 32'h5678);
        chk("b2b_a1", 32'(wb_addr), 32'd6);
        step();
        chk("b2b_pulse", 32'(wb_valid), 32'd0);
        $display("txn b2b alu pair done");

        do_txn(6'b100011, 5'd3, 32'h0, 32'h100, 1'b0, 3, 0, 32'hDEADBEEF);
        do_txn(6'b100000, 5'd4, 32'h0, 32'h103, 1'b0, 0, 0, 32'h80FF0102);
        chk("lb_const", wb_data, 32'hFFFFFF80);
        do_txn(6'b100100, 5'd4, 32'h0, 32'h103, 1'b0, 0, 1, 32'h80FF0102);
        chk("lbu_const", wb_data, 32'h00000080);
        do_txn(6'b100001, 5'd8, 32'h0, 32'h102, 1'b0, 1, 0, 32'h80FF0102);
        chk("lh_const", wb_data, 32'hFFFF80FF);
        do_txn(6'b101000, 5'd9, 32'h000000AB, 32'h101, 1'b0, 0, 0, 32'h0);
        do_txn(6'b101001, 5'd9, 32'h0000BEEF, 32'h102, 1'b0, 2, 0, 32'h0);
        do_txn(6'b100011, 5'd0, 32'h0, 32'h104, 1'b0, 0, 0, 32'h12345678);
        do_txn(6'b000000, 5'd0, 32'h0, 32'h99, 1'b1, 0, 0, 32'h0);
        do_txn(6'b100011, 5'd2, 32'h0, 32'h102, 1'b0, 0, 0, 32'hCAFEF00D);

        // Reset while waiting for read data
        in_valid = 1'b1; in_opcode = 6'b100011; in_rt = 5'd7; in_eff_addr = 32'h200;
        step();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        step();
        mem_rvalid = 1'b0;
        chk("rst_mid_nowb", 32'(wb_valid), 32'd0);
        chk("rst_mid_idle", 32'(in_ready), 32'd1);
        $display("txn reset during WAIT_RD");

        for (int t = 0; t < 60; t++) begin
            logic [5:0]  op;
            logic [4:0]  rt;
            logic [31:0] addr;
            op   = op_pool[$urandom_range(0, 10)];
            rt   = 5'($urandom_range(0, 31));
            addr = $urandom & 32'h0000FFFF;
            if ($urandom % 2 == 1) begin
                step();
                chk("gap_nowb", 32'(wb_valid), 32'd0);
            end
            do_txn(op, rt, $urandom, addr, 1'($urandom % 2), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
